// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: RCU state encoding and sync byte default.
package usb_rx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RCV_SYNC = 3'd1,
        CHK_SYNC = 3'd2,
        RCV_BYTE = 3'd3,
        STORE    = 3'd4,
        EOP_WAIT = 3'd5,
        ERR_WAIT = 3'd6,
        ERR_IDLE = 3'd7
    } rcu_state_t;

endpackage

// File: rtl/rcu.sv
// Receiver control unit: tracks packet framing, strobes data bytes into the RX FIFO
// and flags sync or EOP framing errors.
module rcu
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [7:0] byte_count,
    output rcu_state_t state_dbg
);

    // No handshake: every input is a single-cycle pulse or a level, consumed when
    // the current state cares about it; w_enable is a one-cycle write with no back-pressure.

    rcu_state_t state;
    rcu_state_t next_state;
    logic       mid_byte;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_edge) next_state = RCV_SYNC;
            end
            RCV_SYNC: begin
                if (byte_received)              next_state = CHK_SYNC;
                else if (shift_enable && eop)   next_state = ERR_WAIT;
            end
            CHK_SYNC: begin
                if (rcv_data == SYNC_BYTE) next_state = RCV_BYTE;
                else                       next_state = ERR_WAIT;
            end
            RCV_BYTE: begin
                // A completed byte wins over a coincident EOP sample.
                if (byte_received)                          next_state = STORE;
                else if (shift_enable && eop && !mid_byte)  next_state = EOP_WAIT;
                else if (shift_enable && eop && mid_byte)   next_state = ERR_WAIT;
            end
            STORE: begin
                next_state = RCV_BYTE;
            end
            EOP_WAIT: begin
                if (d_edge) next_state = IDLE;
            end
            ERR_WAIT: begin
                if (d_edge && !eop) next_state = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) next_state = RCV_SYNC;
            end
            default: next_state = IDLE;
        endcase
    end

    // mid_byte marks that at least one bit of the current data byte has been sampled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mid_byte <= 1'b0;
        end else if (state == CHK_SYNC) begin
            mid_byte <= 1'b0;
        end else if (state == RCV_BYTE) begin
            if (byte_received)              mid_byte <= 1'b0;
            else if (shift_enable && !eop)  mid_byte <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_count <= 8'h00;
        end else if ((next_state == RCV_SYNC) && (state != RCV_SYNC)) begin
            byte_count <= 8'h00;
        end else if ((state == STORE) && (byte_count != 8'hFF)) begin
            byte_count <= byte_count + 8'h01;
        end
    end

    always_comb begin
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
        case (state)
            RCV_SYNC, CHK_SYNC, RCV_BYTE, EOP_WAIT: rcving = 1'b1;
            STORE: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
            end
            ERR_WAIT: begin
                rcving  = 1'b1;
                r_error = 1'b1;
            end
            ERR_IDLE: r_error = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_rcu.sv
// Directed-plus-random bench for rcu: packet-level reference model of FIFO writes,
// byte counts and error flag behaviour.
module tb_rcu;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [7:0] byte_count;
    rcu_state_t state_dbg;

    int errors = 0;
    int checks = 0;
    int wen_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    rcu #(.SYNC_BYTE(8'h80)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .byte_count   (byte_count),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // write monitor: every FIFO strobe captures the byte presented with it
    always @(negedge clk) begin
        if (w_enable) begin
            wen_count = wen_count + 1;
            got_q.push_back(rcv_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        wen_count = 0;
    endtask

    // driver: one bit sample, optionally the last bit of a byte and/or an EOP sample
    task automatic shift_bit(input logic with_br, input logic with_eop, input logic [7:0] data);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        shift_enable  = 1'b1;
        eop           = with_eop;
        byte_received = with_br;
        if (with_br) rcv_data = data;
        tick();
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        eop           = 1'b0;
    endtask

    // full byte; leaves the DUT one cycle past CHK_SYNC / STORE
    task automatic send_byte(input logic [7:0] data);
        for (int i = 0; i < 7; i++) shift_bit(1'b0, 1'b0, 8'h00);
        shift_bit(1'b1, 1'b0, data);
        tick();
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_nwr"}, 32'(wen_count), 32'(exp_q.size()));
        check({tag, "_nq"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int n;
        logic [7:0] b;
        int sat_n;

        n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0;
        shift_enable = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;

        // reset state
        #2;
        check("rst_rcving", 32'(rcving), 32'd0);
        check("rst_wen", 32'(w_enable), 32'd0);
        check("rst_rerr", 32'(r_error), 32'd0);
        check("rst_bc", 32'(byte_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        tick();
        n_rst = 1'b1;
        tick();

        // good packet: sync, A5, 3C, EOP on a byte boundary
        clear_model();
        pulse_edge();
        check("good_rcving", 32'(rcving), 32'd1);
        send_byte(8'h80);
        b = 8'hA5; exp_q.push_back(b); send_byte(b);
        b = 8'h3C; exp_q.push_back(b); send_byte(b);
        shift_bit(1'b0, 1'b1, 8'h00);
        check("good_eopwait", 32'(state_dbg), 32'(EOP_WAIT));
        pulse_edge();
        check("good_state", 32'(state_dbg), 32'(IDLE));
        check("good_bc", 32'(byte_count), 32'd2);
        check("good_rerr", 32'(r_error), 32'd0);
        check("good_rcving_end", 32'(rcving), 32'd0);
        compare_stream("good");

        // random good packets, byte_count must hold in IDLE afterwards
        for (int p = 0; p < 4; p++) begin
            clear_model();
            n = $urandom_range(0, 6);
            pulse_edge();
            check("rnd_bc_clr", 32'(byte_count), 32'd0);
            send_byte(8'h80);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send_byte(b);
            end
            shift_bit(1'b0, 1'b1, 8'h00);
            pulse_edge();
            repeat (3) tick();
            check("rnd_state", 32'(state_dbg), 32'(IDLE));
            check("rnd_bc", 32'(byte_count), 32'(n));
            check("rnd_rerr", 32'(r_error), 32'd0);
            compare_stream("rnd");
        end

        // bad sync byte
        do_reset();
        clear_model();
        pulse_edge();
        for (int i = 0; i < 7; i++) shift_bit(1'b0, 1'b0, 8'h00);
        shift_bit(1'b1, 1'b0, 8'h81);
        check("bad_chk", 32'(state_dbg), 32'(CHK_SYNC));
        tick();
        check("bad_errwait", 32'(state_dbg), 32'(ERR_WAIT));
        check("bad_rerr", 32'(r_error), 32'd1);
        check("bad_rcving", 32'(rcving), 32'd1);
        check("bad_bc", 32'(byte_count), 32'd0);
        check("bad_nwr", 32'(wen_count), 32'd0);
        d_edge = 1'b1; eop = 1'b1;
        tick();
        check("bad_edge_eop_hold", 32'(state_dbg), 32'(ERR_WAIT));
        eop = 1'b0;
        tick();
        d_edge = 1'b0;
        check("bad_erridle_rcving", 32'(rcving), 32'd0);
        check("bad_erridle_rerr", 32'(r_error), 32'd1);
        repeat (3) tick();
        check("bad_erridle_hold", 32'(r_error), 32'd1);
        pulse_edge();
        check("bad_resync_rerr", 32'(r_error), 32'd0);
        check("bad_resync_state", 32'(state_dbg), 32'(RCV_SYNC));

        // EOP in the middle of a data byte
        do_reset();
        clear_model();
        pulse_edge();
        send_byte(8'h80);
        for (int i = 0; i < 3; i++) shift_bit(1'b0, 1'b0, 8'h00);
        shift_bit(1'b0, 1'b1, 8'h00);
        check("mid_rerr", 32'(r_error), 32'd1);
        check("mid_rcving", 32'(rcving), 32'd1);
        repeat (2) tick();
        check("mid_rcving_hold", 32'(rcving), 32'd1);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        check("mid_erridle_rcving", 32'(rcving), 32'd0);
        check("mid_erridle_rerr", 32'(r_error), 32'd1);
        pulse_edge();
        check("mid_clear_rerr", 32'(r_error), 32'd0);
        check("mid_nwr", 32'(wen_count), 32'd0);

        // byte_received coincident with eop: the byte is stored
        do_reset();
        clear_model();
        pulse_edge();
        send_byte(8'h80);
        for (int i = 0; i < 7; i++) shift_bit(1'b0, 1'b0, 8'h00);
        b = 8'h5A; exp_q.push_back(b);
        shift_bit(1'b1, 1'b1, b);
        check("coinc_wen", 32'(w_enable), 32'd1);
        tick();
        check("coinc_state", 32'(state_dbg), 32'(RCV_BYTE));
        shift_bit(1'b0, 1'b1, 8'h00);
        check("coinc_eopwait", 32'(state_dbg), 32'(EOP_WAIT));
        check("coinc_bc", 32'(byte_count), 32'd1);
        check("coinc_rerr", 32'(r_error), 32'd0);
        pulse_edge();
        compare_stream("coinc");

        // saturation of byte_count
        clear_model();
        sat_n = 260;
        pulse_edge();
        send_byte(8'h80);
        for (int k = 0; k < sat_n; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b);
        end
        shift_bit(1'b0, 1'b1, 8'h00);
        pulse_edge();
        check("sat_bc", 32'(byte_count), (sat_n > 255) ? 32'hFF : 32'(sat_n));
        check("sat_state", 32'(state_dbg), 32'(IDLE));
        compare_stream("sat");
        pulse_edge();
        check("sat_bc_clr", 32'(byte_count), 32'd0);

        // asynchronous reset in the middle of a data byte
        do_reset();
        clear_model();
        pulse_edge();
        send_byte(8'h80);
        for (int i = 0; i < 3; i++) shift_bit(1'b0, 1'b0, 8'h00);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_rcving", 32'(rcving), 32'd0);
        check("arst_wen", 32'(w_enable), 32'd0);
        check("arst_rerr", 32'(r_error), 32'd0);
        check("arst_bc", 32'(byte_count), 32'd0);
        for (int i = 0; i < 4; i++) shift_bit(1'b0, 1'b0, 8'h00);
        shift_bit(1'b1, 1'b0, 8'h77);
        n_rst = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) shift_bit(1'b0, 1'b0, 8'h00);
        shift_bit(1'b1, 1'b0, 8'h11);
        repeat (2) tick();
        check("arst_idle", 32'(state_dbg), 32'(IDLE));
        check("arst_rcving_after", 32'(rcving), 32'd0);
        check("arst_nwr", 32'(wen_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
